// File: rtl/attention_pkg.sv
// Shared definitions for the attention feeder: default tile geometry and the
// feeder control state encoding.
package attention_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_K_TILE     = 16;

   typedef enum logic [1:0] {
      IDLE,
      START,
      STREAM,
      WAIT_OUT
   } feeder_state_e;

endpackage

// File: rtl/attention_tile_buf.sv
// Tile storage: one write port, one combinational read port, each entry holds
// a packed {q, k, v} triple. Storage is not cleared by reset.
module attention_tile_buf
   import attention_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int K_TILE     = DEF_K_TILE,
   localparam int AW        = $clog2(K_TILE),
   localparam int EW        = 3 * DATA_WIDTH
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [EW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [EW-1:0] rd_data
);

   logic [EW-1:0] mem [K_TILE];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/attention_feeder.sv
// Streams one host-loaded q/k/v tile into an attention core, one beat per
// handshake, then captures the single core result.
module attention_feeder
   import attention_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int K_TILE     = DEF_K_TILE,
   localparam int AW        = $clog2(K_TILE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_q,
   input  logic [DATA_WIDTH-1:0] wr_k,
   input  logic [DATA_WIDTH-1:0] wr_v,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  wr_err,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  core_start,
   output logic                  core_in_valid,
   input  logic                  core_in_ready,
   output logic [DATA_WIDTH-1:0] core_q,
   output logic [DATA_WIDTH-1:0] core_k,
   output logic [DATA_WIDTH-1:0] core_v,
   input  logic                  core_out_valid,
   output logic                  core_out_ready,
   input  logic [DATA_WIDTH-1:0] core_out_data
);

   feeder_state_e             state, state_n;
   logic [AW-1:0]             rd_ptr;
   logic [3*DATA_WIDTH-1:0]   rd_data;
   logic                      accept, fire, last, capture;

   assign accept  = (state == IDLE) && start;
   assign fire    = (state == STREAM) && core_in_ready;
   assign last    = (rd_ptr == AW'(K_TILE - 1));
   assign capture = (state == WAIT_OUT) && core_out_valid;

   // Host writes only land while idle; writes during a run are dropped.
   attention_tile_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .K_TILE     (K_TILE)
   ) u_buf (
      .clk     (clk),
      .wr_en   (wr_en && !busy),
      .wr_addr (wr_addr),
      .wr_data ({wr_q, wr_k, wr_v}),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   assign core_q = rd_data[3*DATA_WIDTH-1:2*DATA_WIDTH];
   assign core_k = rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
   assign core_v = rd_data[DATA_WIDTH-1:0];

   assign core_in_valid  = (state == STREAM);
   assign core_out_ready = (state == WAIT_OUT);

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:     if (start)          state_n = START;
         START:                        state_n = STREAM;
         STREAM:   if (fire && last)   state_n = WAIT_OUT;
         WAIT_OUT: if (core_out_valid) state_n = IDLE;
         default:                      state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rd_ptr     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         wr_err     <= 1'b0;
         result     <= '0;
         core_start <= 1'b0;
      end else begin
         state      <= state_n;
         core_start <= (state_n == START);
         done       <= capture;
         wr_err     <= wr_en && busy;
         if (accept)       busy <= 1'b1;
         else if (capture) busy <= 1'b0;
         // Pointer parks on the last entry rather than wrapping.
         if (accept)              rd_ptr <= '0;
         else if (fire && !last)  rd_ptr <= rd_ptr + 1'b1;
         if (capture) result <= core_out_data;
      end
   end

endmodule

// File: tb/tb_attention_feeder.sv
// Directed bench for attention_feeder with a behavioural core that sums
// q*k*v over a tile and returns bits [23:8] of the sum.
module tb_attention_feeder;

   localparam int DW = 16;
   localparam int KT = 16;

   logic          clk = 1'b0;
   logic          rst, wr_en, start;
   logic [3:0]    wr_addr;
   logic [DW-1:0] wr_q, wr_k, wr_v;
   logic          busy, done, wr_err, core_start, core_in_valid, core_in_ready;
   logic [DW-1:0] result, core_q, core_k, core_v, core_out_data;
   logic          core_out_valid, core_out_ready;

   attention_feeder #(.DATA_WIDTH(DW), .K_TILE(KT)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_q(wr_q), .wr_k(wr_k), .wr_v(wr_v), .start(start),
      .busy(busy), .done(done), .wr_err(wr_err), .result(result),
      .core_start(core_start), .core_in_valid(core_in_valid),
      .core_in_ready(core_in_ready), .core_q(core_q), .core_k(core_k),
      .core_v(core_v), .core_out_valid(core_out_valid),
      .core_out_ready(core_out_ready), .core_out_data(core_out_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          ramp;        // entries q=k=v=addr+1 instead of constants
      logic [15:0] q, k, v;
      bit          toggle_rdy;
      int          out_delay;
      logic [15:0] exp_result;
   } vec_t;

   vec_t vecs[4];

   int n_vec = 0, n_bad = 0;

   // core model / monitor state
   bit          toggle_rdy = 0, hs_pend = 0, have_res = 0, prev_stall = 0;
   int          out_delay = 0, dly = 0, rdy_ph = 0, run_beats = 0;
   int          beat_total = 0, stall_err = 0, cs_cnt = 0, done_cnt = 0, err_cnt = 0;
   logic [31:0] acc = 0;
   logic [47:0] prev_beat = 0;
   logic [47:0] beat_log[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      core_in_ready  = 1'b0;
      core_out_valid = 1'b0;
      core_out_data  = '0;
      forever begin
         @(negedge clk);
         if (hs_pend) begin
            core_out_valid = 1'b0; hs_pend = 0; have_res = 0; run_beats = 0; acc = 0;
         end
         core_in_ready = toggle_rdy ? (rdy_ph == 0) : 1'b1;
         rdy_ph = (rdy_ph == 2) ? 0 : rdy_ph + 1;
         if (core_in_valid) begin
            if (prev_stall && ({core_q, core_k, core_v} !== prev_beat)) stall_err++;
            prev_beat  = {core_q, core_k, core_v};
            prev_stall = !core_in_ready;
            if (core_in_ready) begin
               beat_log.push_back(prev_beat);
               beat_total++;
               run_beats++;
               acc = acc + 32'(core_q) * 32'(core_k) * 32'(core_v);
               if (run_beats == KT) begin have_res = 1; dly = out_delay; end
            end
         end else prev_stall = 0;
         if (have_res && !core_out_valid) begin
            if (dly == 0) begin core_out_valid = 1'b1; core_out_data = acc[23:8]; end
            else dly--;
         end
         if (core_out_valid && core_out_ready) hs_pend = 1;
         if (core_start) cs_cnt++;
         if (done)       done_cnt++;
         if (wr_err)     err_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clear_counts();
      beat_total = 0; stall_err = 0; cs_cnt = 0; done_cnt = 0; err_cnt = 0;
      prev_stall = 0; beat_log.delete();
   endtask

   // Last write shares its cycle with start, so it must be part of the run.
   task automatic load_and_start(input vec_t v);
      for (int a = 0; a < KT; a++) begin
         wr_en   = 1'b1;
         wr_addr = 4'(a);
         wr_q    = v.ramp ? 16'(a + 1) : v.q;
         wr_k    = v.ramp ? 16'(a + 1) : v.k;
         wr_v    = v.ramp ? 16'(a + 1) : v.v;
         start   = (a == KT - 1);
         tick();
      end
      wr_en = 1'b0;
      start = 1'b0;
   endtask

   task automatic rerun();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int i;
      for (i = 0; i < 400; i++) begin
         tick();
         if (done) break;
      end
      check({name, " done_seen"}, 32'(i < 400), 32'd1);
      check({name, " busy_at_done"}, 32'(busy), 32'd0);
   endtask

   task automatic settle();
      tick(); tick();
   endtask

   initial begin
      vecs[0] = '{"const_2_3_4",   1'b0, 16'd2,  16'd3,  16'd4,   1'b0, 0, 16'h0001};
      vecs[1] = '{"const16_late",  1'b0, 16'd16, 16'd16, 16'd16,  1'b0, 4, 16'h0100};
      vecs[2] = '{"const_1_1_255", 1'b0, 16'd1,  16'd1,  16'd255, 1'b1, 1, 16'h000F};
      vecs[3] = '{"ramp_toggle",   1'b1, 16'd0,  16'd0,  16'd0,   1'b1, 0, 16'h0048};

      rst = 1'b1; wr_en = 1'b0; start = 1'b0; wr_addr = '0;
      wr_q = '0; wr_k = '0; wr_v = '0;
      repeat (3) tick();
      check("reset ctl", {26'd0, busy, done, wr_err, core_start, core_in_valid, core_out_ready}, 32'd0);
      check("reset result", 32'(result), 32'd0);
      rst = 1'b0;
      tick();

      for (int n = 0; n < 4; n++) begin
         int order_err;
         toggle_rdy = vecs[n].toggle_rdy;
         out_delay  = vecs[n].out_delay;
         clear_counts();
         load_and_start(vecs[n]);
         check({vecs[n].name, " busy_after_start"}, 32'(busy), 32'd1);
         check({vecs[n].name, " core_start"}, 32'(core_start), 32'd1);
         wait_done(vecs[n].name);
         check({vecs[n].name, " result"}, 32'(result), 32'(vecs[n].exp_result));
         settle();
         check({vecs[n].name, " core_start_cnt"}, cs_cnt, 1);
         check({vecs[n].name, " done_cnt"}, done_cnt, 1);
         check({vecs[n].name, " beats"}, beat_total, KT);
         check({vecs[n].name, " stall_stable"}, stall_err, 0);
         check({vecs[n].name, " wr_err_cnt"}, err_cnt, 0);
         order_err = 0;
         foreach (beat_log[i]) begin
            logic [47:0] e;
            e = vecs[n].ramp ? {16'(i + 1), 16'(i + 1), 16'(i + 1)}
                             : {vecs[n].q, vecs[n].k, vecs[n].v};
            if (beat_log[i] !== e) order_err++;
         end
         check({vecs[n].name, " beat_order"}, order_err, 0);
      end

      // write during a run is dropped and flagged; buffer still holds the ramp
      clear_counts();
      rerun();
      tick();
      wr_en = 1'b1; wr_addr = 4'd3; wr_q = 16'hAA; wr_k = 16'hAA; wr_v = 16'hAA;
      tick();
      wr_en = 1'b0;
      check("busy_write wr_err", 32'(wr_err), 32'd1);
      wait_done("busy_write");
      check("busy_write result", 32'(result), 32'h48);
      settle();
      check("busy_write err_cnt", err_cnt, 1);
      clear_counts();
      rerun();
      wait_done("rerun");
      check("rerun result", 32'(result), 32'h48);
      settle();
      check("rerun addr3", beat_log.size() > 3 ? beat_log[3] : 48'd0, {16'd4, 16'd4, 16'd4});

      // reset mid-stream, then a clean full run from address 0
      toggle_rdy = 1'b0;
      out_delay  = 0;
      clear_counts();
      rerun();
      begin
         int i;
         for (i = 0; i < 100; i++) begin
            if (beat_total >= 7) break;
            tick();
         end
         check("midreset reached_7", 32'(i < 100), 32'd1);
      end
      rst = 1'b1;
      tick();
      check("midreset ctl", {26'd0, busy, done, wr_err, core_start, core_in_valid, core_out_ready}, 32'd0);
      check("midreset result", 32'(result), 32'd0);
      rst = 1'b0;
      acc = 0; run_beats = 0; have_res = 0;
      clear_counts();
      tick();
      rerun();
      wait_done("after_reset");
      check("after_reset result", 32'(result), 32'h48);
      settle();
      check("after_reset beats", beat_total, KT);
      check("after_reset first", beat_log.size() > 0 ? beat_log[0] : 48'd0, {16'd1, 16'd1, 16'd1});

      // start held high: back-to-back runs, no extra core_start while busy
      clear_counts();
      start = 1'b1;
      begin
         int ndone, i;
         ndone = 0;
         for (i = 0; i < 400; i++) begin
            tick();
            if (done) begin
               ndone++;
               if (ndone == 1) begin
                  check("b2b busy_at_done", 32'(busy), 32'd0);
                  tick();
                  check("b2b busy_reaccept", 32'(busy), 32'd1);
               end else begin
                  start = 1'b0;
                  break;
               end
            end
         end
         start = 1'b0;
         check("b2b two_dones", ndone, 2);
      end
      settle();
      check("b2b core_start_cnt", cs_cnt, 2);
      check("b2b done_cnt", done_cnt, 2);
      check("b2b beats", beat_total, 2 * KT);
      check("b2b result", 32'(result), 32'h48);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/attention_feeder.md
ATTENTION_FEEDER -- requirements
Module: attention_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of q/k/v elements and of the result.
REQ-002 Parameter K_TILE, default 16, number of q/k/v entries per tile (≥2).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  host write strobe into the tile buffer.
REQ-006 wr_addr  input  clog2(K_TILE)  buffer entry index.
REQ-007 wr_q / wr_k / wr_v  input  DATA_WIDTH each  entry data.
REQ-008 start  input  1  host request to run one tile.
REQ-009 busy  output  1  high from accepted start until done.
REQ-010 done  output  1  one-cycle pulse when the result is captured.
REQ-011 wr_err  output  1  one-cycle pulse when wr_en is dropped while busy.
REQ-012 result  output  DATA_WIDTH  last captured core output, held until the next capture.
REQ-013 core_start  output  1  one-cycle start pulse to the attention core.
REQ-014 core_in_valid  output  1  q/k/v beat valid.
REQ-015 core_in_ready  input  1  core accepts the beat.
REQ-016 core_q / core_k / core_v  output  DATA_WIDTH each  beat data.
REQ-017 core_out_valid  input  1  core result valid.
REQ-018 core_out_ready  output  1  feeder accepts the result.
REQ-019 core_out_data  input  DATA_WIDTH  core result.

Function
REQ-020 The FSM SHALL have states IDLE, START, STREAM, WAIT_OUT; the reset state is IDLE.
REQ-021 IDLE: start=1 → START at the next edge, rd_ptr cleared to 0, busy=1 from that edge.
REQ-022 START: core_start=1 for exactly one cycle, then → STREAM.
REQ-023 STREAM: core_in_valid=1, core_q/k/v = buffer[rd_ptr]; beat fires when core_in_valid && core_in_ready.
REQ-024 On each fire rd_ptr SHALL increment; the fire at rd_ptr==K_TILE-1 → WAIT_OUT with core_in_valid=0 in the next cycle and no rd_ptr wrap issued.
REQ-025 While core_in_valid=1 and core_in_ready=0, core_q/k/v SHALL remain stable and core_in_valid SHALL stay high.
REQ-026 Exactly K_TILE beats SHALL be issued per run, in address order 0..K_TILE-1.
REQ-027 WAIT_OUT: core_out_ready=1; on core_out_valid=1, result ← core_out_data, done pulses in the next cycle, busy=0 in that same cycle, → IDLE.
REQ-028 core_out_ready SHALL be 0 in every state other than WAIT_OUT; core_out_valid outside WAIT_OUT SHALL be ignored.
REQ-029 Buffer write SHALL commit at the edge when wr_en=1 && busy=0; wr_en && busy=1 drops the write and pulses wr_err.
REQ-030 wr_en and start in the same IDLE cycle: the write commits and is included in that run.
REQ-031 start while busy=1 SHALL be ignored (not queued).
REQ-032 Zero-latency back-to-back: start asserted in the done cycle SHALL be accepted (FSM is IDLE that cycle).
REQ-033 Buffer contents persist across runs; a tile may be rerun without rewriting.

Reset
REQ-034 rst=1 SHALL force IDLE, rd_ptr=0, busy=0, done=0, wr_err=0, result=0, core_start=0, core_in_valid=0, core_out_ready=0 at the next edge, including mid-STREAM and mid-WAIT_OUT.
REQ-035 Buffer contents SHALL be unspecified after reset; no reset clearing of storage.

Structure
REQ-036 Shared package attention_pkg SHALL hold the feeder state enum and the default DATA_WIDTH/K_TILE constants.
REQ-037 Tile storage SHALL be a sub-module attention_tile_buf (1 write port, 1 combinational read port, 3×DATA_WIDTH wide, K_TILE deep).
REQ-038 Outputs core_start, done, wr_err, busy SHALL be registered.

Verification
REQ-039 With an attention_core (VALUE_SHIFT 8) attached: all 16 entries q=2,k=3,v=4, start → 1 core_start pulse, 16 beats, result=0x0001 (384>>>8), done once.
REQ-040 Entries q=k=v=addr+1, core_in_ready toggling 1,0,0,1… → beats in order 1..16, data stable during stalls, exactly 16 fires.
REQ-041 wr_en during STREAM to addr 3 → wr_err pulse, rerun shows addr 3 unchanged.
REQ-042 rst during STREAM after 7 beats → all outputs at reset values next cycle; following start issues full 16 beats from addr 0.
REQ-043 start held high continuously → back-to-back runs, each with 16 beats and one done pulse; start during busy never creates extra core_start.
REQ-044 core_out_valid held 3 cycles late in WAIT_OUT → feeder waits, result captured on first valid cycle, done exactly once.
